// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC and sequences instruction fetch.
// Picks next PC (pc+4, J target, branch/JR redirect), runs the
// imem req/ack handshake and holds the fetched word for decode.
// Ports: clk, rst (async, active-high); imem_req/addr/ack/rdata;
// if_valid/if_instr/if_pc/if_pc4 with id_ready; redirect inputs
// redir_pc4, jump/j_imm, br_taken/br_imm, jr/jr_addr; addr_err.
// Option: define BRANCH_DELAY_SLOT_EN for MIPS delay-slot behaviour.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    input  logic        id_ready,
    input  logic [31:0] redir_pc4,
    input  logic        jump,
    input  logic [25:0] j_imm,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic        addr_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, pc4, addr_q, target;
    logic        redir, take, load, clr, err_nx;

    assign pc4   = pc + 32'd4;
    assign redir = jr | jump | br_taken;

    always_comb begin
        target = redir_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
        if (jr)
            target = {jr_addr[31:2], 2'b00};
        else if (jump)
            target = {redir_pc4[31:28], j_imm, 2'b00};
    end

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_q;
    logic [31:0] pend_pc;
    logic        fetch_done;

    // Only one target may be pending; later redirects are dropped.
    assign take       = redir & ~pend_q;
    assign fetch_done = (state == FETCH) & imem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 1'b0;
            pend_pc <= 32'd0;
        end else if (take && !fetch_done) begin
            pend_q  <= 1'b1;
            pend_pc <= target;
        end else if (fetch_done) begin
            pend_q  <= 1'b0;
        end
    end
`else
    assign take = redir;
`endif

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        load      = 1'b0;
        clr       = 1'b0;
        imem_req  = 1'b0;
        imem_addr = pc;
        err_nx    = take & jr & (jr_addr[1:0] != 2'b00);
        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    load     = 1'b1;
                    pc_nx    = pc4;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (id_ready) begin
                    clr      = 1'b1;
                    state_nx = FETCH;
                end
            end
            DRAIN: begin
                // Outstanding request is kept alive until its ack.
                imem_req  = 1'b1;
                imem_addr = addr_q;
                if (imem_ack)
                    state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
`ifdef BRANCH_DELAY_SLOT_EN
        // The word being fetched is the delay slot; it is kept and
        // the target replaces pc+4 once that word is acked.
        if (take && fetch_done)
            pc_nx = target;
        else if (pend_q && fetch_done)
            pc_nx = pend_pc;
`else
        if (take) begin
            pc_nx = target;
            load  = 1'b0;
            clr   = 1'b1;
            if ((state == FETCH || state == DRAIN) && !imem_ack)
                state_nx = DRAIN;
            else
                state_nx = FETCH;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            addr_q   <= 32'd0;
            if_valid <= 1'b0;
            if_instr <= 32'd0;
            if_pc    <= 32'd0;
            if_pc4   <= 32'd0;
            addr_err <= 1'b0;
        end else begin
            pc       <= pc_nx;
            addr_err <= err_nx;
            // Remembers the address of a request that may be drained.
            if (state == FETCH)
                addr_q <= pc;
            if (load) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= pc;
                if_pc4   <= pc4;
            end else if (clr) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule
